// File: rtl/warp_launch_ctrl.sv
// Warp launch controller: accepts software warps, requests registers from the RAU and
// tracks which of the eight hardware warp slots are occupied.
module warp_launch_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        Launch_Valid,
  input  logic [31:0] Launch_SWWarp,
  input  logic [2:0]  Launch_Nreq,
  output logic        Launch_Ready,
  input  logic [4:0]  RAU_TM_Available,
  input  logic        RAU_TM_Done,
  input  logic        IB_RAU_ExitEN,
  input  logic [2:0]  IB_Exit_WarpID,
  output logic        TM_RAU_AlloEN,
  output logic [2:0]  TM_RAU_HWWarp,
  output logic [31:0] TM_RAU_SWWarp,
  output logic [2:0]  TM_RAU_Nreq,
  output logic [7:0]  Warp_Valid,
  output logic [3:0]  Active_Count,
  output logic        Alloc_Timeout
);

  typedef enum logic [1:0] {StIdle, StCheck, StIssue, StWait} state_e;

  state_e      state_q, state_d;
  logic [31:0] sw_q, sw_d;
  logic [3:0]  need_q, need_d;
  logic [2:0]  hw_q, hw_d;
  logic [7:0]  valid_q, valid_d;
  logic [3:0]  count_q, count_d;
  logic        timeout_q, timeout_d;
  logic [4:0]  wait_cnt_q, wait_cnt_d;

  logic        any_free;
  logic [2:0]  free_slot;
  logic [3:0]  need_in;
  logic        accept;
  logic        alloc_en;
  logic        set_en;

  assign any_free = ~&valid_q;
  assign need_in  = {1'b0, Launch_Nreq} + {3'b000, Launch_Nreq[0]};
  assign accept   = (state_q == StIdle) && any_free && Launch_Valid;
  assign alloc_en = (state_q == StIssue) && !IB_RAU_ExitEN;

  // Offers are only taken in IDLE, so valid_q never hides an in-flight slot:
  // the single outstanding request is the only one that can be missing from it.
  always_comb begin
    free_slot = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!valid_q[i]) free_slot = 3'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    sw_d       = sw_q;
    need_d     = need_q;
    hw_d       = hw_q;
    timeout_d  = timeout_q;
    wait_cnt_d = wait_cnt_q;
    set_en     = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          sw_d    = Launch_SWWarp;
          need_d  = need_in;
          hw_d    = free_slot;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if ({1'b0, need_q} <= RAU_TM_Available) state_d = StIssue;
      end
      StIssue: begin
        if (alloc_en) begin
          wait_cnt_d = 5'd0;
          state_d    = StWait;
        end
      end
      StWait: begin
        wait_cnt_d = wait_cnt_q + 5'd1;
        if (RAU_TM_Done) begin
          set_en  = 1'b1;
          state_d = StIdle;
        end else if (wait_cnt_d == 5'd31) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Set is applied after clear so a completion beats a same-slot exit.
  always_comb begin
    valid_d = valid_q;
    if (IB_RAU_ExitEN) valid_d[IB_Exit_WarpID] = 1'b0;
    if (set_en) valid_d[hw_q] = 1'b1;
    count_d = 4'd0;
    for (int i = 0; i < 8; i++) begin
      count_d = count_d + {3'b000, valid_d[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      sw_q       <= 32'd0;
      need_q     <= 4'd0;
      hw_q       <= 3'd0;
      valid_q    <= 8'd0;
      count_q    <= 4'd0;
      timeout_q  <= 1'b0;
      wait_cnt_q <= 5'd0;
    end else begin
      state_q    <= state_d;
      sw_q       <= sw_d;
      need_q     <= need_d;
      hw_q       <= hw_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      timeout_q  <= timeout_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign Launch_Ready  = (state_q == StIdle) && any_free;
  assign TM_RAU_AlloEN = alloc_en;
  assign TM_RAU_HWWarp = hw_q;
  assign TM_RAU_SWWarp = sw_q;
  assign TM_RAU_Nreq   = need_q[2:0];
  assign Warp_Valid    = valid_q;
  assign Active_Count  = count_q;
  assign Alloc_Timeout = timeout_q;

endmodule

// File: tb/tb_warp_launch_ctrl.sv
// Self-checking bench for warp_launch_ctrl: directed scenarios plus randomized launch
// transactions checked against a slot-occupancy model.
module tb_warp_launch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        Launch_Valid = 1'b0;
  logic [31:0] Launch_SWWarp = 32'd0;
  logic [2:0]  Launch_Nreq = 3'd0;
  logic        Launch_Ready;
  logic [4:0]  RAU_TM_Available = 5'd0;
  logic        RAU_TM_Done = 1'b0;
  logic        IB_RAU_ExitEN = 1'b0;
  logic [2:0]  IB_Exit_WarpID = 3'd0;
  logic        TM_RAU_AlloEN;
  logic [2:0]  TM_RAU_HWWarp;
  logic [31:0] TM_RAU_SWWarp;
  logic [2:0]  TM_RAU_Nreq;
  logic [7:0]  Warp_Valid;
  logic [3:0]  Active_Count;
  logic        Alloc_Timeout;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] m_valid = 8'd0;
  logic       m_timeout = 1'b0;

  warp_launch_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .Launch_Valid     (Launch_Valid),
    .Launch_SWWarp    (Launch_SWWarp),
    .Launch_Nreq      (Launch_Nreq),
    .Launch_Ready     (Launch_Ready),
    .RAU_TM_Available (RAU_TM_Available),
    .RAU_TM_Done      (RAU_TM_Done),
    .IB_RAU_ExitEN    (IB_RAU_ExitEN),
    .IB_Exit_WarpID   (IB_Exit_WarpID),
    .TM_RAU_AlloEN    (TM_RAU_AlloEN),
    .TM_RAU_HWWarp    (TM_RAU_HWWarp),
    .TM_RAU_SWWarp    (TM_RAU_SWWarp),
    .TM_RAU_Nreq      (TM_RAU_Nreq),
    .Warp_Valid       (Warp_Valid),
    .Active_Count     (Active_Count),
    .Alloc_Timeout    (Alloc_Timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] lowest_free(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      if (!v[i]) return 3'(i);
    end
    return 3'd0;
  endfunction

  // Apply one cycle's inputs and let combinational outputs settle.
  task automatic drive(input logic v, input logic done, input logic [4:0] avail,
                       input logic ex, input logic [2:0] exid);
    Launch_Valid     = v;
    RAU_TM_Done      = done;
    RAU_TM_Available = avail;
    IB_RAU_ExitEN    = ex;
    IB_Exit_WarpID   = exid;
    #1;
  endtask

  // Clock edge; model applies exit then completion, and may raise the timeout.
  task automatic advance(input bit set_en, input logic [2:0] set_slot, input bit set_to);
    logic       ex;
    logic [2:0] id;
    ex = IB_RAU_ExitEN;
    id = IB_Exit_WarpID;
    @(posedge clk);
    #1;
    if (ex) m_valid[id] = 1'b0;
    if (set_en) m_valid[set_slot] = 1'b1;
    if (set_to) m_timeout = 1'b1;
    check_eq("warp_valid", {24'd0, Warp_Valid}, {24'd0, m_valid});
    check_eq("active_count", {28'd0, Active_Count}, $countones(m_valid));
    check_eq("alloc_timeout", {31'd0, Alloc_Timeout}, {31'd0, m_timeout});
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 1'b0, 3'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_valid = 8'd0;
    m_timeout = 1'b0;
    #1;
    check_eq("rst_valid", {24'd0, Warp_Valid}, 32'd0);
    check_eq("rst_count", {28'd0, Active_Count}, 32'd0);
    check_eq("rst_timeout", {31'd0, Alloc_Timeout}, 32'd0);
    check_eq("rst_hw", {29'd0, TM_RAU_HWWarp}, 32'd0);
    check_eq("rst_sw", TM_RAU_SWWarp, 32'd0);
    check_eq("rst_nreq", {29'd0, TM_RAU_Nreq}, 32'd0);
    check_eq("rst_ready", {31'd0, Launch_Ready}, 32'd1);
    check_eq("rst_alloen", {31'd0, TM_RAU_AlloEN}, 32'd0);
  endtask

  function automatic logic rnd_pct(input int pct);
    return ($urandom_range(0, 99) < pct);
  endfunction

  // One launch. done_dly: 1..31 = Done in that WAIT cycle, 0 = withhold, -1 = stop in WAIT.
  task automatic launch(input logic [31:0] sw, input logic [2:0] n, input int stall,
                        input int mask, input int done_dly, input bit collide, input int ex_pct);
    int         need;
    int         st;
    logic [2:0] slot;
    logic [2:0] need3;
    need  = int'(n) + int'(n[0]);
    need3 = 3'(need);
    st    = (need == 0) ? 0 : stall;
    slot  = lowest_free(m_valid);
    Launch_SWWarp = sw;
    Launch_Nreq   = n;
    drive(1'b1, rnd_pct(30), 5'($urandom_range(0, 16)), rnd_pct(ex_pct), 3'($urandom_range(0, 7)));
    check_eq("idle_ready", {31'd0, Launch_Ready}, 32'd1);
    check_eq("idle_alloen", {31'd0, TM_RAU_AlloEN}, 32'd0);
    advance(1'b0, 3'd0, 1'b0);
    check_eq("latched_hw", {29'd0, TM_RAU_HWWarp}, {29'd0, slot});
    check_eq("latched_sw", TM_RAU_SWWarp, sw);
    check_eq("latched_nreq", {29'd0, TM_RAU_Nreq}, {29'd0, need3});
    for (int i = 0; i < st; i++) begin
      drive(1'b1, rnd_pct(30), 5'($urandom_range(0, need - 1)), rnd_pct(ex_pct),
            3'($urandom_range(0, 7)));
      check_eq("stall_alloen", {31'd0, TM_RAU_AlloEN}, 32'd0);
      check_eq("busy_ready", {31'd0, Launch_Ready}, 32'd0);
      advance(1'b0, 3'd0, 1'b0);
    end
    drive(1'b0, rnd_pct(30), 5'($urandom_range(need, 16)), rnd_pct(ex_pct),
          3'($urandom_range(0, 7)));
    check_eq("check_alloen", {31'd0, TM_RAU_AlloEN}, 32'd0);
    advance(1'b0, 3'd0, 1'b0);
    for (int i = 0; i < mask; i++) begin
      drive(1'b0, rnd_pct(30), 5'($urandom_range(0, 16)), 1'b1, 3'($urandom_range(0, 7)));
      check_eq("masked_alloen", {31'd0, TM_RAU_AlloEN}, 32'd0);
      advance(1'b0, 3'd0, 1'b0);
    end
    drive(1'b0, 1'b0, 5'($urandom_range(0, 16)), 1'b0, 3'd0);
    check_eq("issue_alloen", {31'd0, TM_RAU_AlloEN}, 32'd1);
    check_eq("issue_hw", {29'd0, TM_RAU_HWWarp}, {29'd0, slot});
    check_eq("issue_sw", TM_RAU_SWWarp, sw);
    check_eq("issue_nreq", {29'd0, TM_RAU_Nreq}, {29'd0, need3});
    advance(1'b0, 3'd0, 1'b0);
    if (done_dly == -1) begin
      for (int k = 1; k <= 3; k++) begin
        drive(1'b0, 1'b0, 5'd16, 1'b0, 3'd0);
        advance(1'b0, 3'd0, 1'b0);
      end
    end else if (done_dly == 0) begin
      for (int k = 1; k <= 31; k++) begin
        drive(1'b0, 1'b0, 5'($urandom_range(0, 16)), rnd_pct(ex_pct), 3'($urandom_range(0, 7)));
        check_eq("wait_alloen", {31'd0, TM_RAU_AlloEN}, 32'd0);
        advance(1'b0, 3'd0, k == 31);
      end
      check_eq("timeout_ready", {31'd0, Launch_Ready}, {31'd0, m_valid != 8'hFF});
    end else begin
      for (int k = 1; k < done_dly; k++) begin
        drive(1'b0, 1'b0, 5'($urandom_range(0, 16)), rnd_pct(ex_pct), 3'($urandom_range(0, 7)));
        check_eq("wait_alloen", {31'd0, TM_RAU_AlloEN}, 32'd0);
        check_eq("wait_ready", {31'd0, Launch_Ready}, 32'd0);
        advance(1'b0, 3'd0, 1'b0);
      end
      if (collide) drive(1'b0, 1'b1, 5'd0, 1'b1, slot);
      else drive(1'b0, 1'b1, 5'd0, rnd_pct(ex_pct), 3'($urandom_range(0, 7)));
      advance(1'b1, slot, 1'b0);
    end
    drive(1'b0, 1'b0, 5'd0, 1'b0, 3'd0);
  endtask

  initial begin
    do_reset();

    // Basic launch: Nreq 3 rounds to 4, Done in the 4th WAIT cycle.
    launch(32'h1234, 3'd3, 0, 0, 4, 1'b0, 0);
    check_eq("basic_valid", {24'd0, Warp_Valid}, 32'h01);
    check_eq("basic_count", {28'd0, Active_Count}, 32'd1);

    // Register stall, then exit-masked issue, then need 8 presented as 0.
    launch(32'hA5A5_0001, 3'd6, 10, 0, 3, 1'b0, 0);
    launch(32'hA5A5_0002, 3'd5, 0, 2, 2, 1'b0, 0);
    launch(32'hA5A5_0003, 3'd7, 4, 1, 31, 1'b0, 0);

    // Fill every slot, confirm offers are refused, then free slot 5 and reuse it.
    while (m_valid != 8'hFF) launch($urandom, 3'($urandom_range(0, 7)), 0, 0, 2, 1'b0, 0);
    drive(1'b1, 1'b0, 5'd16, 1'b0, 3'd0);
    check_eq("full_ready", {31'd0, Launch_Ready}, 32'd0);
    advance(1'b0, 3'd0, 1'b0);
    drive(1'b0, 1'b0, 5'd16, 1'b1, 3'd5);
    advance(1'b0, 3'd0, 1'b0);
    check_eq("exit5_valid", {24'd0, Warp_Valid}, 32'hDF);
    drive(1'b0, 1'b0, 5'd16, 1'b0, 3'd0);
    launch(32'h5555, 3'd2, 0, 0, 1, 1'b0, 0);

    // Completion for slot 2 collides with exit of slot 2.
    do_reset();
    launch(32'h10, 3'd1, 0, 0, 1, 1'b0, 0);
    launch(32'h11, 3'd1, 0, 0, 1, 1'b0, 0);
    launch(32'h12, 3'd2, 0, 0, 3, 1'b1, 0);
    check_eq("collide_bit2", {31'd0, Warp_Valid[2]}, 32'd1);

    // Withheld Done times out; slot stays free and the flag is sticky.
    launch(32'h20, 3'd4, 0, 0, 0, 1'b0, 0);
    check_eq("timeout_slot", {31'd0, Warp_Valid[3]}, 32'd0);
    launch(32'h21, 3'd1, 0, 0, 5, 1'b0, 0);
    check_eq("timeout_sticky", {31'd0, Alloc_Timeout}, 32'd1);

    // Reset mid-WAIT abandons the request.
    launch(32'h30, 3'd2, 0, 0, -1, 1'b0, 0);
    do_reset();

    // Randomized launches interleaved with exits.
    for (int t = 0; t < 60; t++) begin
      if (m_valid == 8'hFF || $urandom_range(0, 3) == 0) begin
        drive(1'b0, rnd_pct(30), 5'($urandom_range(0, 16)), 1'b1, 3'($urandom_range(0, 7)));
        check_eq("rnd_idle_ready", {31'd0, Launch_Ready}, {31'd0, m_valid != 8'hFF});
        advance(1'b0, 3'd0, 1'b0);
      end else begin
        launch($urandom, 3'($urandom_range(0, 7)), $urandom_range(0, 4), $urandom_range(0, 2),
               ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 31)),
               rnd_pct(20), 25);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/warp_launch_ctrl.md
WARP_LAUNCH_CTRL -- requirements
Module: warp_launch_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
REQ-003 SHALL have port Launch_Valid  input  1  dispatcher offers a software warp for launch.
REQ-004 SHALL have port Launch_SWWarp  input  32  software warp ID offered.
REQ-005 SHALL have port Launch_Nreq  input  3  registers requested, 0..7.
REQ-006 SHALL have port Launch_Ready  output  1  block accepts an offer this cycle.
REQ-007 SHALL have port RAU_TM_Available  input  5  free register count reported by the register allocation unit, 0..16.
REQ-008 SHALL have port RAU_TM_Done  input  1  one-cycle pulse: current allocation finished.
REQ-009 SHALL have port IB_RAU_ExitEN  input  1  warp exit strobe from the instruction buffer (snooped).
REQ-010 SHALL have port IB_Exit_WarpID  input  3  hardware warp ID exiting.
REQ-011 SHALL have port TM_RAU_AlloEN  output  1  allocation request strobe.
REQ-012 SHALL have port TM_RAU_HWWarp  output  3  hardware warp slot being allocated.
REQ-013 SHALL have port TM_RAU_SWWarp  output  32  software warp ID of the request.
REQ-014 SHALL have port TM_RAU_Nreq  output  3  register count of the request, rounded up to even.
REQ-015 SHALL have port Warp_Valid  output  8  one bit per hardware slot: slot occupied.
REQ-016 SHALL have port Active_Count  output  4  population count of Warp_Valid, 0..8.
REQ-017 SHALL have port Alloc_Timeout  output  1  sticky error: allocation not acknowledged in time.

Function
REQ-018 SHALL implement FSM states IDLE, CHECK, ISSUE, WAIT.
REQ-019 Launch_Ready SHALL be 1 only in IDLE with at least one Warp_Valid bit clear.
REQ-020 IDLE: on Launch_Valid & Launch_Ready, SHALL latch SWWarp; SHALL latch Nreq rounded up to even (odd n -> n+1, 7 -> 8 held internally as 4 bits); SHALL latch the lowest-index free slot as HWWarp; next state CHECK.
REQ-021 CHECK: if latched need <= RAU_TM_Available, next state ISSUE; otherwise remain in CHECK (stall, no timeout).
REQ-022 ISSUE: TM_RAU_AlloEN SHALL equal NOT IB_RAU_ExitEN (combinational); when asserted, next state WAIT; when masked by an exit, remain in ISSUE and retry the next cycle.
REQ-023 TM_RAU_AlloEN SHALL be 0 in every state other than ISSUE.
REQ-024 TM_RAU_HWWarp, TM_RAU_SWWarp and TM_RAU_Nreq SHALL hold the latched values from CHECK through WAIT. TM_RAU_Nreq SHALL present need[2:0], so need 8 presents 0 (RAU-side convention).
REQ-025 WAIT: a 5-bit counter SHALL clear on entry and increment each cycle; on RAU_TM_Done, Warp_Valid[HWWarp] SHALL set on the next edge and the FSM SHALL return to IDLE.
REQ-026 WAIT: if the counter reaches 31 without RAU_TM_Done, Alloc_Timeout SHALL set; the slot SHALL stay free; the FSM SHALL return to IDLE.
REQ-027 RAU_TM_Done outside WAIT SHALL be ignored.
REQ-028 In any state, IB_RAU_ExitEN SHALL clear Warp_Valid[IB_Exit_WarpID] on the next edge; an exit for an already-clear slot SHALL have no effect.
REQ-029 If set (REQ-025) and clear (REQ-028) target different slots in the same cycle, both SHALL apply. If they target the same slot, the set SHALL win.
REQ-030 Active_Count SHALL be registered and consistent with Warp_Valid in the same cycle.
REQ-031 Slot selection SHALL exclude the slot being allocated, so no duplicate HWWarp exists in flight.

Reset
REQ-032 With rst=0 at a clock edge: state IDLE; Warp_Valid=0; Active_Count=0; Alloc_Timeout=0; TM_RAU_HWWarp=0; TM_RAU_SWWarp=0; TM_RAU_Nreq=0; wait counter=0.
REQ-033 Reset asserted in any state SHALL abandon an in-flight request with no slot set; Launch_Ready=1 on the first cycle after rst returns to 1.
REQ-034 Alloc_Timeout SHALL clear only on reset.

Verification
REQ-035 Launch SW=0x1234, Nreq=3, Available=16; Done 4 cycles after AlloEN -> one AlloEN pulse, HWWarp=0, Nreq=4, Warp_Valid=0x01, Active_Count=1.
REQ-036 Nreq=6, Available=4 for 10 cycles, then 8 -> AlloEN stays 0 during the stall and asserts on the cycle after Available=8.
REQ-037 ISSUE with ExitEN=1 for 2 cycles -> AlloEN=0 for those 2 cycles, then 1; exactly one handoff to WAIT.
REQ-038 Warp_Valid=0xFF -> Launch_Ready=0; exit ID 5 -> Warp_Valid=0xDF; next launch gets HWWarp=5.
REQ-039 Withhold Done after AlloEN -> Alloc_Timeout=1 after 31 WAIT cycles, slot stays clear, Launch_Ready=1.
REQ-040 Done for slot 2 coincides with exit of slot 2 -> Warp_Valid[2]=1.
